// File: rtl/ysyx_25040129_axil_sram_pkg.sv
// rtl/ysyx_25040129_axil_sram_pkg.sv - shared types and constants for the AXI4-Lite SRAM responder
//
// Purpose : response codes, read/write FSM state encodings, LFSR seed and
//           the read response classifier shared by the SRAM responder and
//           its LFSR helper.
// Ports   : none (package).
package ysyx_25040129_axil_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Counter wide enough for 255 base latency plus 15 random extra cycles.
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Out-of-range beats alignment; alignment is only checked for half and
    // word accesses since a byte access is always aligned.
    function automatic logic [1:0] rd_resp_code(
        input logic       in_range,
        input logic [2:0] size,
        input logic [1:0] lo
    );
        logic [1:0] code;
        code = RESP_OKAY;
        if (!in_range) begin
            code = RESP_DECERR;
        end else if ((size == 3'd1) && lo[0]) begin
            code = RESP_SLVERR;
        end else if ((size == 3'd2) && (lo != 2'b00)) begin
            code = RESP_SLVERR;
        end
        return code;
    endfunction

endpackage

// File: rtl/ysyx_25040129_lfsr16.sv
// rtl/ysyx_25040129_lfsr16.sv - 16-bit Fibonacci LFSR used for random response delays
//
// Purpose : free-running pseudo-random source, taps 16,14,13,11, reseeded on reset.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset (loads the seed)
//           out  - current LFSR state
module ysyx_25040129_lfsr16
    import ysyx_25040129_axil_sram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic feedback;

    assign feedback = out[15] ^ out[13] ^ out[12] ^ out[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= LFSR_SEED;
        end else begin
            out <= {out[14:0], feedback};
        end
    end

endmodule

// File: rtl/ysyx_25040129_axil_sram.sv
// rtl/ysyx_25040129_axil_sram.sv - AXI4-Lite responder in front of a word-addressed SRAM
//
// Purpose : accepts AR/AW/W requests, performs byte-masked writes and full-word
//           reads, and returns R/B responses after RD_LAT/WR_LAT wait cycles.
//           Read and write channels run independent FSMs.
// Options : RAND_DELAY_EN adds lfsr[3:0] (read) / lfsr[7:4] (write) extra cycles.
// Ports   : clk, rst                              - clock, async active-high reset
//           araddr/arsize/arvalid/arready         - read address channel
//           rdata/rresp/rvalid/rready             - read data channel
//           awaddr/awvalid/awready                - write address channel
//           wdata/wstrb/wvalid/wready             - write data channel
//           bresp/bvalid/bready                   - write response channel
module ysyx_25040129_axil_sram
    import ysyx_25040129_axil_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0f00_0000,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [2:0]  arsize,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Latency source
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rd_lat_eff;
    logic [CNT_W-1:0] wr_lat_eff;

`ifdef RAND_DELAY_EN
    logic [15:0] lfsr;

    ysyx_25040129_lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign rd_lat_eff = CNT_W'(RD_LAT) + CNT_W'(lfsr[3:0]);
    assign wr_lat_eff = CNT_W'(WR_LAT) + CNT_W'(lfsr[7:4]);
`else
    assign rd_lat_eff = CNT_W'(RD_LAT);
    assign wr_lat_eff = CNT_W'(WR_LAT);
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t        r_state;
    rd_state_t        r_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      ar_addr_q;
    logic [2:0]       ar_size_q;

    logic [31:0]      rd_addr_src;
    logic [2:0]       rd_size_src;
    logic [32:0]      rd_off;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_code;
    logic [31:0]      rd_word;
    logic             rd_sample;

    // With RD_LAT=0 the response is sampled on the handshake edge itself, so
    // the live request must be decoded instead of the latched copy.
    assign rd_addr_src = (r_state == R_IDLE) ? araddr : ar_addr_q;
    assign rd_size_src = (r_state == R_IDLE) ? arsize : ar_size_q;

    // Bit 32 is the borrow: set when the address lies below ADDR_BASE.
    assign rd_off      = {1'b0, rd_addr_src} - {1'b0, ADDR_BASE};
    assign rd_in_range = !rd_off[32] && (rd_off[31:0] < SPAN);
    assign rd_idx      = rd_off[IDX_W+1:2];
    assign rd_code     = rd_resp_code(rd_in_range, rd_size_src, rd_addr_src[1:0]);
    assign rd_word     = (rd_code == RESP_OKAY) ? mem[rd_idx] : 32'h0;
    assign rd_sample   = (r_next == R_RESP) && (r_state != R_RESP);

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_next = (rd_lat_eff == '0) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if ((r_state == R_IDLE) && arvalid) begin
                ar_addr_q <= araddr;
                ar_size_q <= arsize;
                r_cnt     <= rd_lat_eff;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (rd_sample) begin
                rdata <= rd_word;
                rresp <= rd_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t        w_state;
    wr_state_t        w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             aw_got;
    logic             w_got;
    logic [31:0]      aw_addr_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;

    logic             aw_hs;
    logic             w_hs;
    logic             wr_both;
    logic [31:0]      wr_addr_src;
    logic [31:0]      wr_data_src;
    logic [3:0]       wr_strb_src;
    logic [32:0]      wr_off;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_commit;

    assign aw_hs   = (w_state == W_IDLE) && !aw_got && awvalid;
    assign w_hs    = (w_state == W_IDLE) && !w_got && wvalid;
    assign wr_both = (aw_got || aw_hs) && (w_got || w_hs);

    // Capture flags stay set until the response is accepted, so in W_WAIT
    // the latched copies are selected; with WR_LAT=0 the live inputs are.
    assign wr_addr_src = aw_got ? aw_addr_q : awaddr;
    assign wr_data_src = w_got ? w_data_q : wdata;
    assign wr_strb_src = w_got ? w_strb_q : wstrb;

    assign wr_off      = {1'b0, wr_addr_src} - {1'b0, ADDR_BASE};
    assign wr_in_range = !wr_off[32] && (wr_off[31:0] < SPAN);
    assign wr_idx      = wr_off[IDX_W+1:2];
    assign wr_commit   = (w_next == W_RESP) && (w_state != W_RESP);

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !aw_got;
                wready  = !w_got;
                if (wr_both) begin
                    w_next = (wr_lat_eff == '0) ? W_RESP : W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt <= CNT_W'(1)) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if ((w_state == W_IDLE) && wr_both) begin
                w_cnt <= wr_lat_eff;
            end else if (w_state == W_WAIT) begin
                w_cnt <= w_cnt - CNT_W'(1);
            end
            if (wr_commit) begin
                bresp <= wr_in_range ? RESP_OKAY : RESP_DECERR;
            end
            if ((w_state == W_RESP) && bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // SRAM storage is not reset; only lanes with their strobe set are written.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_src[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data_src[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ysyx_25040129_axil_sram.md
# ysyx_25040129_axil_sram

AXI4-Lite responder (slave) fronting a word-addressed on-chip SRAM. It is the memory-side endpoint for the LSU's load/store master port: it accepts AR/AW/W requests, performs byte-masked writes and full-word reads, and returns R/B responses after a configurable latency. It handles the read and write channels independently, so one read and one write may be outstanding at the same time.

## Interface
Parameters:
- ADDR_BASE, 32'h0f00_0000, byte address of word 0
- DEPTH_WORDS, 2048, number of 32-bit words (power of two)
- RD_LAT, 1, extra wait cycles between AR handshake and rvalid (0..255)
- WR_LAT, 1, extra wait cycles between last of AW/W handshake and bvalid (0..255)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arsize  in  3  0=byte, 1=half, 2=word
- rdata  out  32  full aligned word; the master extracts bytes/halves
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write byte address
- awvalid / awready  in / out  1  write address handshake
- wdata  in  32  lane-aligned write data
- wstrb  in  4  byte enables
- wvalid / wready  in / out  1  write data handshake
- bresp  out  2  write response code
- bvalid / bready  out / in  1  write response handshake

## Operation
- In range means ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS. Word index = (addr - ADDR_BASE) >> 2.
- Read FSM states:
  - R_IDLE: arready=1. AR handshake latches araddr and arsize and loads the counter with RD_LAT. Next state is R_WAIT, or R_RESP when RD_LAT=0.
  - R_WAIT: counter decrements each cycle; at 0, go to R_RESP.
  - R_RESP: rvalid=1 and rdata/rresp are held stable until rready. On rvalid&rready, return to R_IDLE.
- Read response codes:
  - Out of range: rresp=DECERR, rdata=0.
  - In range but misaligned (half with addr[0]=1; word with addr[1:0]!=0): rresp=SLVERR, rdata=0.
  - Otherwise: rresp=OKAY, rdata=mem[idx].
- Write FSM states:
  - W_IDLE: awready=1 and wready=1. Each channel is captured independently; its ready drops once that channel is captured. When both are captured (same cycle or different cycles), load the counter with WR_LAT and go to W_WAIT.
  - W_WAIT: counter decrements each cycle; at 0, go to W_RESP.
  - W_RESP: bvalid=1 and bresp is held stable until bready. On bvalid&bready, return to W_IDLE.
- The SRAM write is committed on the W_WAIT→W_RESP edge, for lanes with wstrb=1 only.
- Write response codes: out of range gives DECERR with no write; wstrb=0 gives OKAY with no write.
- The FSMs never accept a new request while a response is pending.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. SRAM contents are not reset.
- All handshake outputs are registered or decoded from state only; no combinational path from any input to a ready or valid output.
- Read latency: AR handshake at cycle N gives rvalid at N+1+RD_LAT.
- Write latency: the later of the AW/W handshakes at cycle N gives bvalid at N+1+WR_LAT.
- Back-to-back throughput: one read per 2+RD_LAT cycles when rready is held high.
- Same word read and written, read sampled on the same edge as the write commit: the read returns the old data.
- Reset asserted mid-transaction: any pending response is discarded, both FSMs return to IDLE, and the counters clear.

## Configuration
- RAND_DELAY_EN defined: the effective latency is RD_LAT + lfsr[3:0] (reads) or WR_LAT + lfsr[7:4] (writes), sampled at counter load.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle.
- RAND_DELAY_EN undefined: latency is exactly RD_LAT / WR_LAT and no LFSR is instantiated.

## Structure
- Shared package holds:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - read FSM state encodings
  - write FSM state encodings
  - LFSR seed constant
- One sub-module: ysyx_25040129_lfsr16 (clk, rst, out[15:0]), instantiated only under RAND_DELAY_EN.
- SRAM is an inferred reg array with four byte-lane write enables.

## Test plan
- Reset, then write 32'hDEADBEEF to ADDR_BASE+4 with wstrb=4'hF, AW and W presented in the same cycle → bvalid at +2 cycles, bresp=00; a subsequent read of ADDR_BASE+4 returns 32'hDEADBEEF with rresp=00 at +2 cycles.
- Present AW 3 cycles before W, with wstrb=4'b0100 and wdata=32'h00AB_0000 to a word holding 32'h11223344 → read back 32'h11AB3344. awready is low between the AW handshake and the W handshake.
- Read 32'h0000_0000 (out of range) → rresp=DECERR, rdata=0. Write to the same address → bresp=DECERR and the SRAM is unchanged.
- Half read with arsize=1 at ADDR_BASE+1 → rresp=SLVERR. Word read at ADDR_BASE+2 → SLVERR.
- Hold rready=0 for 5 cycles after rvalid → rvalid and rdata stay stable. Concurrently, a write completes normally, proving the channels are independent.
- Assert rst while in R_WAIT → rvalid=0 and arready=1 immediately. No response appears after rst is released.
